// File: rtl/winograd_pkg.sv
// Shared constants, stream FSM state type and ReLU helper for the Winograd stride-2 pipeline.
package winograd_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_ROWS  = 224;
    localparam int DEF_COLS  = 224;
    localparam int RELU_W    = 64;

    typedef enum logic {
        IDLE,
        STREAM
    } stream_state_t;

    // Operates at a generous fixed width; callers sign-extend in and truncate back out.
    function automatic logic signed [RELU_W-1:0] relu(input logic signed [RELU_W-1:0] x);
        return (x < 0) ? '0 : x;
    endfunction

endpackage

// File: rtl/conv_out_streamer_rise_detect.sv
// Registers a level and emits a one-cycle pulse on each 0->1 transition.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= 1'b0;
        else        level_q <= level;
    end

    // A level still high when reset releases counts as a fresh edge.
    assign pulse = level & ~level_q;

endmodule

// File: rtl/conv_out_streamer.sv
// Snapshots the convolution result array on done and streams it row-major over valid/ready.
module conv_out_streamer
    import winograd_pkg::*;
#(
    parameter int width   = DEF_WIDTH,
    parameter int rows    = DEF_ROWS,
    parameter int cols    = DEF_COLS,
    parameter int RELU_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Convolution_done,
    input  logic signed [width-1:0] data_in [0:rows/2-1][0:cols/2-1],
    output logic signed [width-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last_col,
    output logic                    m_last,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    clear_overrun
);

    localparam int OUT_ROWS = rows / 2;
    localparam int OUT_COLS = cols / 2;
    localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

    stream_state_t           state;
    logic [RW-1:0]           row;
    logic [CW-1:0]           col;
    logic signed [width-1:0] buffer [0:OUT_ROWS-1][0:OUT_COLS-1];
    logic signed [width-1:0] elem;

    logic start;
    logic streaming;
    logic at_last_col;
    logic at_last;
    logic xfer;
    logic final_xfer;
    logic capture;

    rise_detect u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (Convolution_done),
        .pulse (start)
    );

    assign streaming   = (state == STREAM);
    assign at_last_col = (col == CW'(OUT_COLS - 1));
    assign at_last     = at_last_col && (row == RW'(OUT_ROWS - 1));
    assign xfer        = streaming && m_ready;
    assign final_xfer  = xfer && at_last;
    // A start coinciding with the final transfer chains straight into the next frame.
    assign capture     = start && (!streaming || final_xfer);

    always_ff @(posedge clk) begin
        if (capture) buffer <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (at_last) begin
                            row <= '0;
                            col <= '0;
                            if (!start) state <= IDLE;
                        end else if (at_last_col) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     overrun <= 1'b0;
        else if (clear_overrun)                         overrun <= 1'b0;
        else if (start && streaming && !final_xfer)     overrun <= 1'b1;
    end

    assign elem = buffer[row][col];

    always_comb begin
        m_data = '0;
        if (streaming) begin
            if (RELU_EN != 0) m_data = width'(relu(RELU_W'(elem)));
            else              m_data = elem;
        end
    end

    assign m_valid    = streaming;
    assign busy       = streaming;
    assign m_last_col = streaming && at_last_col;
    assign m_last     = streaming && at_last;

endmodule

// File: tb/tb_conv_out_streamer.sv
// Directed bench for conv_out_streamer on a 4x4 output array, pass-through and ReLU instances.
module tb_conv_out_streamer;

    localparam int W = 16;
    localparam int R = 8;
    localparam int C = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, done, m_ready, clr;
    logic signed [W-1:0] din [0:R/2-1][0:C/2-1];
    logic signed [W-1:0] d0, d1;
    logic v0, v1, lc0, lc1, l0, l1, b0, b1, o0, o1;

    int total = 0;
    int bad   = 0;

    conv_out_streamer #(.width(W), .rows(R), .cols(C), .RELU_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Convolution_done(done), .data_in(din),
        .m_data(d0), .m_valid(v0), .m_ready(m_ready), .m_last_col(lc0),
        .m_last(l0), .busy(b0), .overrun(o0), .clear_overrun(clr)
    );

    conv_out_streamer #(.width(W), .rows(R), .cols(C), .RELU_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Convolution_done(done), .data_in(din),
        .m_data(d1), .m_valid(v1), .m_ready(m_ready), .m_last_col(lc1),
        .m_last(l1), .busy(b1), .overrun(o1), .clear_overrun(clr)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int off);
        for (int r = 0; r < R/2; r++)
            for (int c = 0; c < C/2; c++)
                din[r][c] = W'(r*4 + c + off);
    endtask

    task automatic pulse_start();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic run_frame(input int off, input bit stall, input int inj_at, input int inj_off);
        int idx = 0;
        int ph = 0;
        bit injected = 1'b0;
        longint e;
        while (idx < 16 && ph < 200) begin
            m_ready = stall ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            done = 1'b0;
            if (idx == inj_at && !injected) begin
                load(inj_off);
                done = 1'b1;
                injected = 1'b1;
            end
            check("valid", v0, 1);
            if (!v0) break;
            e = off + idx;
            check("data_pass", d0, e);
            check("data_relu", d1, (e < 0) ? 0 : e);
            check("last_col", lc0, (idx % 4 == 3));
            check("last", l0, (idx == 15));
            check("busy", b0, 1);
            check("valid_relu", v1, 1);
            if (m_ready) idx++;
            ph++;
            step();
        end
        done = 1'b0;
        m_ready = 1'b1;
        check("frame_len", idx, 16);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, v0, 0);
        check({tag, "_busy"}, b0, 0);
        check({tag, "_last"}, l0, 0);
    endtask

    initial begin
        rst_n = 1'b0; done = 1'b0; m_ready = 1'b0; clr = 1'b0;
        load(0);
        repeat (2) step();
        check("rst_valid", v0, 0);
        check("rst_busy", b0, 0);
        check("rst_data", d0, 0);
        check("rst_last_col", lc0, 0);
        check("rst_last", l0, 0);
        check("rst_overrun", o0, 0);
        rst_n = 1'b1;
        step();
        check_idle("post_rst");

        // plain ramp 0..15
        load(0);
        pulse_start();
        run_frame(0, 1'b0, -1, 0);
        check_idle("f1_end");

        // negative values exercise ReLU
        load(-8);
        pulse_start();
        run_frame(-8, 1'b0, -1, 0);
        check_idle("f2_end");

        // ready pattern 1,0,0,1
        load(20);
        pulse_start();
        run_frame(20, 1'b1, -1, 0);
        check_idle("f3_end");

        // mid-frame start is dropped and flags overrun
        load(0);
        pulse_start();
        run_frame(0, 1'b0, 5, 100);
        check("overrun_set", o0, 1);
        check_idle("f4_end");
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("overrun_clr", o0, 0);

        // start on the final transfer chains frames with no bubble
        load(30);
        pulse_start();
        run_frame(30, 1'b0, 15, 60);
        check("b2b_valid", v0, 1);
        check("b2b_data", d0, 60);
        check("b2b_overrun", o0, 0);
        run_frame(60, 1'b0, -1, 0);
        check("b2b_overrun_end", o0, 0);
        check_idle("f5_end");

        // asynchronous reset mid-frame, then done held high across release
        load(0);
        pulse_start();
        m_ready = 1'b1;
        repeat (7) step();
        check("pre_rst_data", d0, 7);
        rst_n = 1'b0;
        #1;
        check("async_valid", v0, 0);
        check("async_busy", b0, 0);
        check("async_last", l0, 0);
        check("async_data", d0, 0);
        done = 1'b1;
        load(50);
        step();
        rst_n = 1'b1;
        step();
        run_frame(50, 1'b0, -1, 0);
        check_idle("f6_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
